// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_responder
// Brief    : Fetch-side instruction memory responder with a fixed-latency read
//            pipe, an in-order response queue, a redirect flush and a preload port.
//            Optional access-fault reporting is enabled by IMEM_RESP_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [31:0] io_req_addr,
  output logic        io_resp_valid,
  input  logic        io_resp_ready,
  output logic [31:0] io_resp_data,
  output logic        io_resp_err,
  input  logic        io_flush,
  input  logic        io_load_en,
  input  logic [31:0] io_load_addr,
  input  logic [31:0] io_load_data
);

  localparam int c_IW = $clog2(DEPTH_WORDS);
  localparam int c_CW = $clog2(FIFO_DEPTH + 1);
  localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_CW-1:0] c_FULL      = c_CW'(FIFO_DEPTH);
  localparam logic [c_PW-1:0] c_LAST_SLOT = c_PW'(FIFO_DEPTH - 1);

  logic [31:0]     r_mem [DEPTH_WORDS];
  logic [31:0]     r_rd_data;
  logic [c_IW-1:0] w_req_idx;
  logic [c_IW-1:0] w_load_idx;
  logic            w_req_err;
  logic            w_load_we;
  logic            w_accept;
  logic            w_unused;
  logic [c_CW-1:0] r_count;

  assign w_req_idx  = io_req_addr[c_IW+1:2];
  assign w_load_idx = io_load_addr[c_IW+1:2];

`ifdef IMEM_RESP_ERR_EN
  assign w_req_err = (io_req_addr[1:0] != 2'b00) || (io_req_addr[31:c_IW+2] != '0);
  assign w_load_we = io_load_en && (io_load_addr[31:c_IW+2] == '0);
  assign w_unused  = ^io_load_addr[1:0];
`else
  // Out-of-range bits are dropped so the array aliases modulo DEPTH_WORDS.
  assign w_req_err = 1'b0;
  assign w_load_we = io_load_en;
  assign w_unused  = ^{io_req_addr[31:c_IW+2], io_req_addr[1:0],
                       io_load_addr[31:c_IW+2], io_load_addr[1:0]};
`endif

  assign io_req_ready = (r_count < c_FULL);
  assign w_accept     = io_req_valid && io_req_ready;

  // Read-before-write: a same-cycle load to the requested word returns old data.
  always_ff @(posedge clock) begin
    if (w_load_we) r_mem[w_load_idx] <= io_load_data;
    if (w_accept)  r_rd_data <= r_mem[w_req_idx];
  end

  // Stage 0 is the array read register; later stages shift unconditionally,
  // since the count limit guarantees the queue always has room.
  logic [LATENCY-1:0]       r_pv;
  logic [LATENCY-1:0]       r_perr;
  logic [LATENCY-1:0][31:0] w_pdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pv   <= '0;
      r_perr <= '0;
    end else begin
      r_pv[0]   <= w_accept;
      r_perr[0] <= w_accept && w_req_err;
      for (int k = 1; k < LATENCY; k++) begin
        r_pv[k]   <= r_pv[k-1] && !io_flush;
        r_perr[k] <= r_perr[k-1];
      end
    end
  end

  assign w_pdata[0] = r_perr[0] ? 32'h0 : r_rd_data;

  generate
    if (LATENCY > 1) begin : g_pipe
      logic [LATENCY-2:0][31:0] r_pdata;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_pdata <= '0;
        else        r_pdata <= w_pdata[LATENCY-2:0];
      end
      for (genvar k = 1; k < LATENCY; k++) begin : g_tap
        assign w_pdata[k] = r_pdata[k-1];
      end
    end
  endgenerate

  // Response queue; the last pipe stage falls through when the queue is empty.
  logic [31:0]           r_q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_q_err;
  logic [c_PW-1:0]       r_wr_ptr;
  logic [c_PW-1:0]       r_rd_ptr;
  logic [c_CW-1:0]       r_q_cnt;
  logic [31:0]           r_last_data;
  logic                  w_q_empty;
  logic                  w_last_v;
  logic                  w_head_v;
  logic [31:0]           w_head_data;
  logic                  w_head_err;
  logic                  w_done;
  logic                  w_push;
  logic                  w_pop;

  assign w_q_empty   = (r_q_cnt == '0);
  assign w_last_v    = r_pv[LATENCY-1];
  assign w_head_v    = !w_q_empty || w_last_v;
  assign w_head_data = w_q_empty ? w_pdata[LATENCY-1] : r_q_data[r_rd_ptr];
  assign w_head_err  = w_q_empty ? r_perr[LATENCY-1]  : r_q_err[r_rd_ptr];
  assign w_done      = w_head_v && io_resp_ready;
  assign w_pop       = !w_q_empty && w_done;
  assign w_push      = w_last_v && !(w_q_empty && w_done);

  function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
    return (p == c_LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= w_pdata[LATENCY-1];
      r_q_err[r_wr_ptr]  <= r_perr[LATENCY-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_q_cnt  <= '0;
    end else if (io_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_q_cnt  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_q_cnt <= r_q_cnt + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

  // A response handshaking in the flush cycle is still delivered, so only
  // the surviving redirected request remains counted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        r_count <= '0;
    else if (io_flush) r_count <= c_CW'(w_accept);
    else               r_count <= r_count + c_CW'(w_accept) - c_CW'(w_done);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        r_last_data <= '0;
    else if (w_head_v) r_last_data <= w_head_data;
  end

  assign io_resp_valid = w_head_v;
  assign io_resp_data  = w_head_v ? w_head_data : r_last_data;
  assign io_resp_err   = w_head_v && w_head_err;

endmodule
`default_nettype wire
